// File: rtl/debounce_pkg.sv
// Shared debounce definitions: FSM state encodings and small decode helpers.
// Bit 1 of every state encoding is the debounced output level, and bit 0
// differs from bit 1 exactly in the two qualifying (wait) states.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'b00,
        S_WAIT_HIGH = 2'b01,
        S_HIGH      = 2'b11,
        S_WAIT_LOW  = 2'b10
    } state_t;

    // Debounced level carried by a state (its bit 1).
    function automatic logic state_level(input state_t s);
        return s[1];
    endfunction

    // True while a candidate level change is being qualified.
    function automatic logic state_busy(input state_t s);
        return s[1] ^ s[0];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk
// domain. Reusable by any input block; both flops clear on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_d;
    logic meta_q;
    logic sync_d;
    logic sync_q;

    // Next values: the raw input enters the first stage, which feeds the second.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer: synchronizes a bouncing mechanical input and accepts a
// new level only after it has held for STABLE_CYCLES consecutive cycles.
// The output is decoded straight from the state register, so it is glitch
// free and can feed an edge-detecting single pulser directly.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic signal_in,
    output logic signal_out,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_t           state_d;
    state_t           state_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (signal_in),
        .q     (s)
    );

    // Next-state and counter logic; the counter only runs in wait states and
    // is cleared on every state change, so it can never pass CNT_LAST.
    always_comb begin
        state_d = state_q;
        count_d = '0;
        case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                end else if (count_q == CNT_LAST) begin
                    state_d = S_HIGH;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (s) begin
                    state_d = S_HIGH;
                end else if (count_q == CNT_LAST) begin
                    state_d = S_LOW;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
            end
        endcase
    end

    // State and counter registers; reset discards any partial qualification.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOW;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign signal_out = state_level(state_q);
    assign busy       = state_busy(state_q);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with STABLE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are observed at the
// same point, so "edge n" below means the n-th rising edge after the change.
module tb_button_debouncer;

    localparam int unsigned STABLE = 4;

    logic clk = 1'b0;
    logic reset;
    logic signal_in;
    logic signal_out;
    logic busy;

    logic pulser_q;
    logic pulse;

    int checks   = 0;
    int failures = 0;

    logic [5:0] bounce_pat = 6'b101101;
    logic [4:0] press_pat  = 5'b10101;
    logic [2:0] release_pat = 3'b010;

    button_debouncer #(.STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .signal_in  (signal_in),
        .signal_out (signal_out),
        .busy       (busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Downstream single pulser: one-cycle pulse on each debounced rise.
    always @(posedge clk) begin
        if (reset) pulser_q <= 1'b0;
        else       pulser_q <= signal_out;
    end
    assign pulse = signal_out & ~pulser_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        signal_in = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (signal_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_out edge%0d: got %b expected 0", e, signal_out);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_busy edge%0d: got %b expected 0", e, busy);
            end
            checks++;
            if (dut.count_q !== 2'd0) begin
                failures++;
                $display("[TB] FAIL reset_count edge%0d: got %0d expected 0", e, dut.count_q);
            end
        end
        signal_in = 1'b0;
        reset     = 1'b0;
        for (int e = 0; e < 4; e++) tick();
    endtask

    task automatic test_clean_rise();
        signal_in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if (signal_out !== (e >= 7)) begin
                failures++;
                $display("[TB] FAIL rise_out edge%0d: got %b expected %b", e, signal_out, (e >= 7));
            end
            checks++;
            if (busy !== (e >= 3 && e <= 6)) begin
                failures++;
                $display("[TB] FAIL rise_busy edge%0d: got %b expected %b", e, busy, (e >= 3 && e <= 6));
            end
        end
    endtask

    task automatic test_clean_fall();
        // Two-cycle low glitch while high must be ignored.
        signal_in = 1'b0;
        tick();
        tick();
        signal_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (signal_out !== 1'b1) begin
                failures++;
                $display("[TB] FAIL lowglitch_out edge%0d: got %b expected 1", e, signal_out);
            end
        end
        signal_in = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (signal_out !== (e < 7)) begin
                failures++;
                $display("[TB] FAIL fall_out edge%0d: got %b expected %b", e, signal_out, (e < 7));
            end
            checks++;
            if (busy !== (e >= 3 && e <= 6)) begin
                failures++;
                $display("[TB] FAIL fall_busy edge%0d: got %b expected %b", e, busy, (e >= 3 && e <= 6));
            end
        end
    endtask

    task automatic test_short_glitch();
        logic busy_seen;
        busy_seen = 1'b0;
        signal_in = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) signal_in = 1'b0;
            if (busy === 1'b1) busy_seen = 1'b1;
            checks++;
            if (signal_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL glitch_out edge%0d: got %b expected 0", e, signal_out);
            end
        end
        checks++;
        if (busy_seen !== 1'b1) begin
            failures++;
            $display("[TB] FAIL glitch_busy_pulse: got %b expected 1", busy_seen);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL glitch_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_bounce();
        // Pattern sampled on edges P1..P6; final 0->1 sample is P6, rise at P12.
        signal_in = bounce_pat[5];
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (signal_out !== (n >= 12)) begin
                failures++;
                $display("[TB] FAIL bounce_out edge%0d: got %b expected %b", n, signal_out, (n >= 12));
            end
            if (n < 6) signal_in = bounce_pat[5-n];
            else       signal_in = 1'b1;
        end
    endtask

    task automatic test_reset_mid_wait();
        reset     = 1'b1;
        signal_in = 1'b0;
        tick();
        reset = 1'b0;
        for (int e = 0; e < 3; e++) tick();
        signal_in = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midwait_busy_before: got %b expected 1", busy);
        end
        checks++;
        if (dut.count_q !== 2'd2) begin
            failures++;
            $display("[TB] FAIL midwait_count_before: got %0d expected 2", dut.count_q);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (signal_out !== 1'b0 || busy !== 1'b0 || dut.count_q !== 2'd0) begin
            failures++;
            $display("[TB] FAIL midwait_reset: got out=%b busy=%b count=%0d expected 0 0 0",
                     signal_out, busy, dut.count_q);
        end
        reset = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            tick();
            checks++;
            if (signal_out !== (r >= 7)) begin
                failures++;
                $display("[TB] FAIL midwait_out edge%0d: got %b expected %b", r, signal_out, (r >= 7));
            end
            checks++;
            if (busy !== (r >= 3 && r <= 6)) begin
                failures++;
                $display("[TB] FAIL midwait_busy edge%0d: got %b expected %b", r, busy, (r >= 3 && r <= 6));
            end
        end
    endtask

    task automatic test_chain();
        int   pulses;
        int   max_width;
        int   width;
        reset     = 1'b1;
        signal_in = 1'b0;
        tick();
        reset = 1'b0;
        for (int e = 0; e < 3; e++) tick();
        for (int p = 1; p <= 2; p++) begin
            pulses    = 0;
            max_width = 0;
            width     = 0;
            for (int n = 0; n < 20; n++) begin
                signal_in = (n < 5) ? press_pat[4-n] : 1'b1;
                tick();
                if (pulse === 1'b1) begin
                    if (width == 0) pulses++;
                    width++;
                    if (width > max_width) max_width = width;
                end else begin
                    width = 0;
                end
            end
            checks++;
            if (pulses != 1) begin
                failures++;
                $display("[TB] FAIL chain_press%0d_pulses: got %0d expected 1", p, pulses);
            end
            for (int n = 0; n < 18; n++) begin
                signal_in = (n < 3) ? release_pat[2-n] : 1'b0;
                tick();
                if (pulse === 1'b1) begin
                    if (width == 0) pulses++;
                    width++;
                    if (width > max_width) max_width = width;
                end else begin
                    width = 0;
                end
            end
            checks++;
            if (pulses != 1) begin
                failures++;
                $display("[TB] FAIL chain_release%0d_pulses: got %0d expected 1", p, pulses);
            end
            checks++;
            if (max_width != 1) begin
                failures++;
                $display("[TB] FAIL chain_press%0d_width: got %0d expected 1", p, max_width);
            end
            checks++;
            if (signal_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL chain_release%0d_out: got %b expected 0", p, signal_out);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        signal_in = 1'b0;
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_short_glitch();
        test_bounce();
        test_reset_mid_wait();
        test_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 500000, giving the number of consecutive clock cycles the synchronized input must hold a new level before the output accepts it; legal range 2 to 2^24.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 Port signal_in, input, 1 bit: raw, asynchronous, bouncing mechanical button/switch level, active high.
REQ-005 Port signal_out, output, 1 bit: debounced, registered level that feeds the downstream single pulser.
REQ-006 Port busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-007 signal_in SHALL pass through a two-flop synchronizer before any other logic uses it; the synchronized level is called s.
REQ-008 The FSM SHALL have four states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
REQ-009 In S_LOW: s=1 -> S_WAIT_HIGH with count cleared to 0; s=0 -> stay.
REQ-010 In S_WAIT_HIGH: s=0 -> S_LOW, count cleared; s=1 and count=STABLE_CYCLES-1 -> S_HIGH, count cleared; otherwise count+1.
REQ-011 In S_HIGH: s=0 -> S_WAIT_LOW with count cleared; s=1 -> stay.
REQ-012 In S_WAIT_LOW: s=1 -> S_HIGH, count cleared; s=0 and count=STABLE_CYCLES-1 -> S_LOW, count cleared; otherwise count+1.
REQ-013 signal_out SHALL be 1 in S_HIGH and S_WAIT_LOW and 0 in S_LOW and S_WAIT_HIGH, decoded from the state register with no extra delay.
REQ-014 busy SHALL be 1 exactly in S_WAIT_HIGH and S_WAIT_LOW.
REQ-015 Latency: if signal_in changes level and stays stable, signal_out SHALL follow on the (STABLE_CYCLES+3)th rising edge after the first edge that samples the new level. This is 2 synchronizer edges, 1 edge to enter the wait state and STABLE_CYCLES qualifying edges.
REQ-016 Any opposite-level sample of s during a wait state SHALL abort qualification; a glitch shorter than STABLE_CYCLES cycles SHALL never change signal_out.
REQ-017 The counter width SHALL be $clog2(STABLE_CYCLES); the counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-018 The counter SHALL hold 0 in S_LOW and S_HIGH.
REQ-019 signal_out SHALL change at most once per STABLE_CYCLES+1 cycles, whatever the input pattern.

Reset
REQ-020 On reset=1 at a rising clk edge, the block SHALL set both synchronizer flops to 0, the state to S_LOW and count to 0; reset SHALL override all other conditions.
REQ-021 After reset, signal_out=0 and busy=0 SHALL hold from the first edge with reset=1.
REQ-022 Reset asserted mid-qualification (either wait state) SHALL discard the partial count.
REQ-023 If signal_in is high when reset releases, the block SHALL qualify it as a new rising level per REQ-015.

Structure
REQ-024 The state encodings S_LOW=2'b00, S_WAIT_HIGH=2'b01, S_HIGH=2'b11, S_WAIT_LOW=2'b10 SHALL live in the shared debounce_pkg include file; the state's bit 1 equals signal_out.
REQ-025 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff (ports clk, reset, d, q), reusable by other input blocks.
REQ-026 The FSM and counter SHALL reside in button_debouncer and use one sequential process and one combinational next-state process.

Verification (bench uses STABLE_CYCLES=4)
REQ-027 Clean rise: signal_in 0->1 held 20 cycles -> signal_out rises on the 7th edge after the first sampling edge; busy is high for exactly 4 cycles beforehand.
REQ-028 Short glitch: signal_in high for 3 cycles, then low -> signal_out stays 0 throughout; busy pulses, then returns to 0.
REQ-029 Bounce: pattern 1,0,1,1,0,1 then steady 1 -> signal_out rises exactly 7 edges after the final 0->1 sampling edge; there is no earlier rise.
REQ-030 Clean fall: from signal_out=1, signal_in 1->0 held -> signal_out falls on the 7th edge after the first sampling edge; a 2-cycle low glitch leaves signal_out at 1.
REQ-031 Reset mid-wait: assert reset while in S_WAIT_HIGH with count=2 -> next edge gives signal_out=0, busy=0, count=0; with signal_in still high after release, qualification restarts from 0.
REQ-032 Chain check: button_debouncer driving single_pulser, with a bounced press -> exactly one 1-cycle signal_out pulse from the pulser per press.
